// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver. Finds the start bit on the
// synchronised line, samples each data bit at mid-bit (LSB first), checks
// the stop bit and emits a one-cycle done/error strobe with the word.
//
// Handshake: there is no back-pressure. rx_done is a one-cycle strobe;
// rx_data is valid on that cycle and is held until the next completion.
// rx_error is only ever high on an rx_done cycle.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_error,
    output logic                 rx_busy
);

    // Tick counter must reach SB_TICKS-1 (up to 31 for two stop bits).
    localparam int S_W = (SB_TICKS > 16) ? $clog2(SB_TICKS) : 4;
    localparam int N_W = $clog2(DATA_BITS);

    localparam logic [S_W-1:0] S_MID  = S_W'(7);
    localparam logic [S_W-1:0] S_BIT  = S_W'(15);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [S_W-1:0]         s_q, s_d;
    logic [N_W-1:0]         n_q, n_d;
    logic [DATA_BITS-1:0]   b_q, b_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   sync1_q, sync2_q;
    logic                   rx_sync;

    assign rx_sync = sync2_q;

    // Two-flop synchroniser for the asynchronous pin; idles high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: counters only move on baud ticks; IDLE reacts at once.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_sync) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (s_q == S_BIT) begin
                        b_d = {rx_sync, b_q[DATA_BITS-1:1]};
                        s_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (s_q == S_STOP) begin
                        rx_data_d = b_q;
                        done_d    = 1'b1;
                        err_d     = ~rx_sync;
                        s_d       = '0;
                        state_d   = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data  = rx_data_q;
    assign rx_done  = done_q;
    assign rx_error = err_q;
    assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into an 8N1 receiver and a 7-bit / two
// stop bit receiver, predicts each word, error flag and completion cycle
// from the frame format, and checks them as the receivers report words.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       rx8, rx7;
    logic [7:0] rx_data8;
    logic       rx_done8, rx_error8, rx_busy8;
    logic [6:0] rx_data7;
    logic       rx_done7, rx_error7, rx_busy7;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected responses: bit 9 = framing error, bits 8:0 = word.
    logic [9:0] exp_q8[$];
    logic [9:0] exp_q7[$];
    int         exp_t8[$];
    int         exp_t7[$];
    logic [7:0] last8;

    uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut8 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx8),
        .rx_data(rx_data8), .rx_done(rx_done8), .rx_error(rx_error8), .rx_busy(rx_busy8)
    );

    uart_rx #(.DATA_BITS(7), .SB_TICKS(32)) dut7 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx7),
        .rx_data(rx_data7), .rx_done(rx_done7), .rx_error(rx_error7), .rx_busy(rx_busy7)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Baud generator: one tick every 4 clocks, sampled on cycles divisible by 4.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            baud_tick = (cyc % 4 == 3);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic set_line(input bit which, input logic v);
        if (which) rx7 = v;
        else       rx8 = v;
    endtask

    // Send one frame. which=0 -> 8N1 receiver, which=1 -> 7-bit / 2 stop bits.
    task automatic send(input bit which, input logic [8:0] data, input bit stop_ok, input bit push);
        int db, sbt, r, frame_ticks;
        db  = which ? 7 : 8;
        sbt = which ? 32 : 16;
        while (cyc % 4 != 0) begin
            @(posedge clk);
            #1;
        end
        r = cyc;
        // Start detected 3 clocks after the edge; completion on the last of
        // (8 + 16*db + sbt) ticks, which fall every 4 clocks after that.
        frame_ticks = 8 + 16 * db + sbt;
        if (push) begin
            if (which) begin
                exp_q7.push_back({~stop_ok, 2'b00, data[6:0]});
                exp_t7.push_back(r + 4 * frame_ticks);
            end else begin
                exp_q8.push_back({~stop_ok, 1'b0, data[7:0]});
                exp_t8.push_back(r + 4 * frame_ticks);
                last8 = data[7:0];
            end
        end
        set_line(which, 1'b0);
        hold(64);
        for (int i = 0; i < db; i++) begin
            set_line(which, data[i]);
            hold(64);
        end
        if (stop_ok) begin
            set_line(which, 1'b1);
            hold(4 * sbt);
        end else begin
            // Low across the stop sample point, then back to idle.
            set_line(which, 1'b0);
            hold(40);
            set_line(which, 1'b1);
            hold(4 * sbt - 40 + 64);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q8.size() != 0 || exp_q7.size() != 0) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_timeout", (k >= 3000), 0);
    endtask

    // Monitor / scoreboard: compares every reported word against the queue.
    logic       prev_done8 = 1'b0;
    logic       prev_done7 = 1'b0;
    logic [9:0] e8, e7;
    int         t8, t7;
    always @(negedge clk) begin
        if (prev_done8) begin
            checks++;
            if (rx_done8) begin errors++; $display("FAIL done8_width: rx_done 1, required 0 at cycle %0d", cyc); end
        end
        if (prev_done7) begin
            checks++;
            if (rx_done7) begin errors++; $display("FAIL done7_width: rx_done 1, required 0 at cycle %0d", cyc); end
        end
        if (rx_error8 && !rx_done8) begin
            checks++; errors++;
            $display("FAIL err8_alone: rx_error 1 without rx_done at cycle %0d", cyc);
        end
        if (rx_error7 && !rx_done7) begin
            checks++; errors++;
            $display("FAIL err7_alone: rx_error 1 without rx_done at cycle %0d", cyc);
        end
        if (rx_done8) begin
            if (exp_q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL done8_unexpected: word %0h at cycle %0d, none expected", rx_data8, cyc);
            end else begin
                e8 = exp_q8.pop_front();
                t8 = exp_t8.pop_front();
                checks++;
                if (rx_data8 !== e8[7:0]) begin errors++; $display("FAIL data8: got %0h, required %0h", rx_data8, e8[7:0]); end
                checks++;
                if (rx_error8 !== e8[9]) begin errors++; $display("FAIL error8: got %0b, required %0b", rx_error8, e8[9]); end
                checks++;
                if (cyc != t8) begin errors++; $display("FAIL time8: done at cycle %0d, required %0d", cyc, t8); end
                checks++;
                if (rx_busy8 !== 1'b0) begin errors++; $display("FAIL busy8_done: got %0b, required 0", rx_busy8); end
            end
        end
        if (rx_done7) begin
            if (exp_q7.size() == 0) begin
                checks++; errors++;
                $display("FAIL done7_unexpected: word %0h at cycle %0d, none expected", rx_data7, cyc);
            end else begin
                e7 = exp_q7.pop_front();
                t7 = exp_t7.pop_front();
                checks++;
                if (rx_data7 !== e7[6:0]) begin errors++; $display("FAIL data7: got %0h, required %0h", rx_data7, e7[6:0]); end
                checks++;
                if (rx_error7 !== e7[9]) begin errors++; $display("FAIL error7: got %0b, required %0b", rx_error7, e7[9]); end
                checks++;
                if (cyc != t7) begin errors++; $display("FAIL time7: done at cycle %0d, required %0d", cyc, t7); end
            end
        end
        prev_done8 = rx_done8;
        prev_done7 = rx_done7;
    end

    // Stimulus
    initial begin
        logic [8:0] d;
        bit         ok;
        reset = 1'b0;
        rx8   = 1'b1;
        rx7   = 1'b1;
        last8 = 8'h00;
        hold(3);
        reset = 1'b1;
        hold(1);

        check("rst_data8", rx_data8, 0);
        check("rst_done8", rx_done8, 0);
        check("rst_err8", rx_error8, 0);
        check("rst_busy8", rx_busy8, 0);
        check("rst_data7", rx_data7, 0);
        check("rst_busy7", rx_busy7, 0);

        // Single frame
        send(1'b0, 9'h055, 1'b1, 1'b1);
        wait_drain();

        // Glitch: low for 3 ticks, rejected at the start-bit midpoint
        while (cyc % 4 != 0) hold(1);
        rx8 = 1'b0;
        hold(12);
        check("glitch_busy", rx_busy8, 1);
        rx8 = 1'b1;
        hold(40);
        check("glitch_idle", rx_busy8, 0);
        check("glitch_data", rx_data8, last8);
        hold(64);

        // Framing error
        send(1'b0, 9'h0A5, 1'b0, 1'b1);
        wait_drain();

        // Back-to-back frames, no idle gap
        send(1'b0, 9'h03C, 1'b1, 1'b1);
        send(1'b0, 9'h0C3, 1'b1, 1'b1);
        wait_drain();

        // Reset in the middle of data bit 3 of an aborted frame
        fork
            send(1'b0, 9'h0FF, 1'b1, 1'b0);
            begin
                hold(64 * 4 + 32);
                reset = 1'b0;
                hold(1);
                reset = 1'b1;
                check("midrst_data8", rx_data8, 0);
                check("midrst_done8", rx_done8, 0);
                check("midrst_err8", rx_error8, 0);
                check("midrst_busy8", rx_busy8, 0);
                last8 = 8'h00;
            end
        join
        hold(64);
        send(1'b0, 9'h012, 1'b1, 1'b1);
        wait_drain();

        // 7 data bits, two stop bits
        send(1'b1, 9'h05A, 1'b1, 1'b1);
        wait_drain();

        // Randomised 8N1 traffic with occasional framing errors and gaps
        for (int i = 0; i < 12; i++) begin
            d  = 9'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send(1'b0, d, ok, 1'b1);
            if ($urandom_range(0, 1) == 1) hold(4 * $urandom_range(1, 40));
        end
        wait_drain();
        check("idle_data8", rx_data8, last8);

        // Randomised 7-bit traffic
        for (int i = 0; i < 4; i++) begin
            d = 9'($urandom_range(0, 127));
            send(1'b1, d, 1'b1, 1'b1);
        end
        wait_drain();

        hold(20);
        check("queue8_empty", exp_q8.size(), 0);
        check("queue7_empty", exp_q7.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
